// File: rtl/id_stage.sv
// Instruction decode stage: IF/ID register, 32x32 register file with
// write-back bypass, control decode, load-use hazard detection and the
// ID/EX pipeline register.
module id_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction_in,
    input  logic [31:0] pc4_in,
    input  logic        flush_in,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        stall_out,
    output logic [31:0] rs_data_out,
    output logic [31:0] rt_data_out,
    output logic [31:0] imm_out,
    output logic [31:0] pc4_out,
    output logic [4:0]  rs_out,
    output logic [4:0]  rt_out,
    output logic [4:0]  rd_out,
    output logic [5:0]  funct_out,
    output logic        reg_write_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic        mem_to_reg_out,
    output logic        alu_src_out,
    output logic        reg_dst_out,
    output logic        branch_out,
    output logic        branch_ne_out,
    output logic        jump_out,
    output logic        lui_out,
    output logic        valid_out,
    output logic        illegal_out
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
        logic reg_dst;
        logic branch;
        logic branch_ne;
        logic jump;
        logic lui;
        logic valid;
        logic illegal;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
    } idex_t;

    // IF/ID register
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;

    // ID/EX register
    ctrl_t idex_ctrl_q, idex_ctrl_d;
    idex_t idex_data_q, idex_data_d;

    // Register file; entry 0 is never written so it stays zero
    logic [31:0] rf_q [32];

    // Instruction fields
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [15:0] imm16;
    ctrl_t       dec_ctrl;
    logic        uses_rt;
    logic [31:0] rs_val, rt_val;

    assign op    = ifid_instr_q[31:26];
    assign rs    = ifid_instr_q[25:21];
    assign rt    = ifid_instr_q[20:16];
    assign rd    = ifid_instr_q[15:11];
    assign funct = ifid_instr_q[5:0];
    assign imm16 = ifid_instr_q[15:0];

    // rt is a source operand only for these formats; for loads/ALU-imm it is the destination
    assign uses_rt = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);

    // Load-use hazard: the load in EX writes a register the instruction in ID reads
    assign stall_out = idex_ctrl_q.mem_read && (idex_data_q.rt != 5'd0) && ifid_valid_q &&
                       ((idex_data_q.rt == rs) || (uses_rt && (idex_data_q.rt == rt)));

    // Register reads with same-cycle write-back forwarding
    always_comb begin
        rs_val = rf_q[rs];
        rt_val = rf_q[rt];
        if (wb_we && (wb_addr == rs)) rs_val = wb_data;
        if (wb_we && (wb_addr == rt)) rt_val = wb_data;
        if (rs == 5'd0) rs_val = '0;
        if (rt == 5'd0) rt_val = '0;
    end

    // Control decode; invalid IF/ID contents and unknown opcodes produce a bubble
    always_comb begin
        dec_ctrl = '0;
        if (ifid_valid_q) begin
            dec_ctrl.valid = 1'b1;
            case (op)
                OP_RTYPE: begin
                    dec_ctrl.reg_write = (ifid_instr_q != 32'd0);  // all-zero word is a NOP
                    dec_ctrl.reg_dst   = 1'b1;
                end
                OP_ADDIU: begin
                    dec_ctrl.reg_write = 1'b1;
                    dec_ctrl.alu_src   = 1'b1;
                end
                OP_LUI: begin
                    dec_ctrl.reg_write = 1'b1;
                    dec_ctrl.alu_src   = 1'b1;
                    dec_ctrl.lui       = 1'b1;
                end
                OP_LW: begin
                    dec_ctrl.reg_write  = 1'b1;
                    dec_ctrl.alu_src    = 1'b1;
                    dec_ctrl.mem_read   = 1'b1;
                    dec_ctrl.mem_to_reg = 1'b1;
                end
                OP_SW: begin
                    dec_ctrl.alu_src   = 1'b1;
                    dec_ctrl.mem_write = 1'b1;
                end
                OP_BEQ: dec_ctrl.branch = 1'b1;
                OP_BNE: begin
                    dec_ctrl.branch    = 1'b1;
                    dec_ctrl.branch_ne = 1'b1;
                end
                OP_J:   dec_ctrl.jump = 1'b1;
                default: begin
                    dec_ctrl.valid   = 1'b0;
                    dec_ctrl.illegal = 1'b1;
                end
            endcase
        end
    end

    // Next state of both pipeline registers; flush wins over stall
    always_comb begin
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        idex_ctrl_d  = '0;
        idex_data_d.rs_data = rs_val;
        idex_data_d.rt_data = rt_val;
        idex_data_d.imm     = (op == OP_LUI) ? {16'd0, imm16} : {{16{imm16[15]}}, imm16};
        idex_data_d.pc4     = ifid_pc4_q;
        idex_data_d.rs      = rs;
        idex_data_d.rt      = rt;
        idex_data_d.rd      = rd;
        idex_data_d.funct   = funct;
        if (flush_in) begin
            ifid_instr_d = '0;
            ifid_pc4_d   = '0;
            ifid_valid_d = 1'b0;
        end else if (!stall_out) begin
            ifid_instr_d = instruction_in;
            ifid_pc4_d   = pc4_in;
            ifid_valid_d = 1'b1;
            idex_ctrl_d  = dec_ctrl;
        end
    end

    // Pipeline registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ifid_instr_q <= '0;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
            idex_ctrl_q  <= '0;
            idex_data_q  <= '0;
        end else begin
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            idex_ctrl_q  <= idex_ctrl_d;
            idex_data_q  <= idex_data_d;
        end
    end

    // Register file write port, independent of stall/flush
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (wb_we && (wb_addr != 5'd0)) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    assign rs_data_out    = idex_data_q.rs_data;
    assign rt_data_out    = idex_data_q.rt_data;
    assign imm_out        = idex_data_q.imm;
    assign pc4_out        = idex_data_q.pc4;
    assign rs_out         = idex_data_q.rs;
    assign rt_out         = idex_data_q.rt;
    assign rd_out         = idex_data_q.rd;
    assign funct_out      = idex_data_q.funct;
    assign reg_write_out  = idex_ctrl_q.reg_write;
    assign mem_read_out   = idex_ctrl_q.mem_read;
    assign mem_write_out  = idex_ctrl_q.mem_write;
    assign mem_to_reg_out = idex_ctrl_q.mem_to_reg;
    assign alu_src_out    = idex_ctrl_q.alu_src;
    assign reg_dst_out    = idex_ctrl_q.reg_dst;
    assign branch_out     = idex_ctrl_q.branch;
    assign branch_ne_out  = idex_ctrl_q.branch_ne;
    assign jump_out       = idex_ctrl_q.jump;
    assign lui_out        = idex_ctrl_q.lui;
    assign valid_out      = idex_ctrl_q.valid;
    assign illegal_out    = idex_ctrl_q.illegal;

endmodule
